// File: rtl/deselector.sv
// Serial-to-parallel demultiplexer that rebuilds a word scanned out through the
// 7-input selector. Each enabled cycle in SHIFT steers Y into slot W[B] and
// advances B. On the last slot the finished word goes into the holding
// register A, and done pulses for one cycle.
module deselector #(
  parameter int WIDTH = 7,
  parameter int SEL_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             enable,
  input  logic             Y,
  output logic [0:SEL_W-1] B,
  output logic [0:WIDTH-1] A,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  // Index of the final slot. Reaching it closes the word, so B never wraps.
  localparam logic [0:SEL_W-1] LAST = SEL_W'(WIDTH - 1);
  localparam logic [0:SEL_W-1] ONE  = SEL_W'(1);

  state_t           state_reg, state_next;
  logic [0:SEL_W-1] b_reg, b_next;
  logic [0:WIDTH-1] w_reg, w_next;   // word under assembly
  logic [0:WIDTH-1] a_reg, a_next;   // last completed word, stable while the next one builds
  logic             done_reg, done_next;

  // Next-state logic. Every register holds unless the current state and inputs say otherwise.
  always_comb begin
    state_next = state_reg;
    b_next     = b_reg;
    w_next     = w_reg;
    a_next     = a_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        // enable and Y are don't-care here, even in the start cycle
        if (start) begin
          w_next     = '0;
          b_next     = '0;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        // start is ignored mid-word, and enable=0 simply stalls
        if (enable) begin
          if (b_reg == LAST) begin
            // The last bit goes straight into A, so the word is published without an extra cycle
            a_next          = w_reg;
            a_next[WIDTH-1] = Y;
            done_next       = 1'b1;
            b_next          = '0;
            state_next      = IDLE;
          end else begin
            w_next[b_reg] = Y;
            b_next        = b_reg + ONE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers. Reset discards any partial word and clears A.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
      b_reg     <= '0;
      w_reg     <= '0;
      a_reg     <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      b_reg     <= b_next;
      w_reg     <= w_next;
      a_reg     <= a_next;
      done_reg  <= done_next;
    end
  end

  // Every output comes straight from a register.
  assign B    = b_reg;
  assign A    = a_reg;
  assign done = done_reg;
  assign busy = (state_reg == SHIFT);

endmodule

// File: tb/tb_deselector.sv
// Directed bench for deselector. The stimulus queues each expected completed word,
// together with the cycle on which it should appear. A monitor pops and checks an
// entry whenever done is seen.
module tb_deselector;

  logic       clock = 1'b0;
  logic       reset, start, enable, Y;
  logic [0:2] B;
  logic [0:6] A;
  logic       busy, done;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic [0:6] word;
    int         at_cyc;
  } exp_t;
  exp_t exp_q[$];

  logic [0:6] prev_a;

  deselector dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .enable(enable),
    .Y     (Y),
    .B     (B),
    .A     (A),
    .busy  (busy),
    .done  (done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // One clock: inputs are driven at a negedge, the DUT samples them at the posedge,
  // and the task returns at the next negedge with the outputs settled.
  task automatic step(input logic s, input logic e, input logic y, input logic r = 1'b0);
    reset  = r;
    start  = s;
    enable = e;
    Y      = y;
    @(negedge clock);
  endtask

  // Monitor: each done must match the head of the scoreboard.
  always @(negedge clock) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("word_A", 32'(A), 32'(e.word));
        chk("done_cycle", 32'(cyc), 32'(e.at_cyc));
      end
    end
  end

  // Sends one word. gap*_len idle cycles are inserted before slot gap*_at.
  // start is also raised alongside slot start_slot (use -1 for none).
  task automatic send_word(input logic [0:6] w, input int gap1_at, input int gap1_len,
                           input int gap2_at, input int gap2_len, input int start_slot);
    step(1'b1, 1'b1, 1'b1);
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("B_after_start", 32'(B), 32'd0);
    for (int k = 0; k < 7; k++) begin
      int gap;
      gap = (k == gap1_at) ? gap1_len : ((k == gap2_at) ? gap2_len : 0);
      for (int g = 0; g < gap; g++) begin
        step(1'b0, 1'b0, ~w[k]);
        chk("B_hold_stall", 32'(B), 32'(k));
        chk("busy_stall", 32'(busy), 32'd1);
        chk("A_stable_stall", 32'(A), 32'(prev_a));
      end
      if (k == 6) begin
        exp_t e;
        e.word   = w;
        e.at_cyc = cyc + 1;
        exp_q.push_back(e);
      end
      step((k == start_slot), 1'b1, w[k]);
      if (k < 6) begin
        chk("B_step", 32'(B), 32'(k + 1));
        chk("busy_shift", 32'(busy), 32'd1);
        chk("A_stable", 32'(A), 32'(prev_a));
      end else begin
        chk("B_after_word", 32'(B), 32'd0);
        chk("busy_after_word", 32'(busy), 32'd0);
      end
    end
    prev_a = w;
  endtask

  initial begin
    int t_first;
    reset = 1'b1; start = 1'b0; enable = 1'b0; Y = 1'b0;
    prev_a = 7'b0000000;
    @(negedge clock);

    // Reset, then idle
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b0);
      chk("idle_A", 32'(A), 32'd0);
      chk("idle_B", 32'(B), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
    end
    $display("tb: reset/idle done");

    // Basic word 1011001
    t_first = cyc;
    send_word(7'b1011001, -1, 0, -1, 0, -1);
    chk("basic_latency", 32'(cyc - t_first), 32'd8);
    $display("tb: basic word A=%b", A);
    step(1'b0, 1'b0, 1'b0);
    chk("done_one_cycle", 32'(done), 32'd0);

    // A different word first, so the stall test proves A holds its previous value
    send_word(7'b0100110, -1, 0, -1, 0, -1);
    step(1'b0, 1'b0, 1'b0);

    // Stalls: 3 cycles after slot 2 and 1 cycle after slot 5, i.e. done 4 cycles later
    t_first = cyc;
    send_word(7'b1011001, 3, 3, 6, 1, -1);
    chk("stall_latency", 32'(cyc - t_first), 32'd12);
    $display("tb: stalled word A=%b", A);
    step(1'b0, 1'b0, 1'b0);

    // start raised at slot 3 must be ignored
    send_word(7'b1110000, -1, 0, -1, 0, 3);
    $display("tb: ignored-start word A=%b", A);

    // enable with Y=1 in IDLE changes nothing
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b1);
      chk("idle_en_A", 32'(A), 32'(prev_a));
      chk("idle_en_B", 32'(B), 32'd0);
      chk("idle_en_busy", 32'(busy), 32'd0);
    end

    // Back-to-back: the second word's start lands in the first word's done cycle
    send_word(7'b1011001, -1, 0, -1, 0, -1);
    t_first = cyc;
    send_word(7'b0111110, -1, 0, -1, 0, -1);
    chk("b2b_spacing", 32'(cyc - t_first), 32'd8);
    $display("tb: back-to-back word A=%b", A);
    step(1'b0, 1'b0, 1'b0);

    // Reset mid-word, after 4 slots
    step(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b1);
    chk("mid_B_before_reset", 32'(B), 32'd4);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    chk("rst_mid_A", 32'(A), 32'd0);
    chk("rst_mid_B", 32'(B), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
    prev_a = 7'b0000000;
    step(1'b0, 1'b0, 1'b0);
    chk("rst_mid_done_after", 32'(done), 32'd0);
    send_word(7'b1100101, -1, 0, -1, 0, -1);
    $display("tb: post-reset word A=%b", A);

    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
